// File: rtl/dino_obstacle_scroller.sv
// dino_obstacle_scroller: world side of the 7-segment dinosaur game.
// Spawns pseudo-random cacti and birds, scrolls them from hex0 toward the
// player next to hex4, times the player's jump, detects collisions and
// keeps a saturating score.
// Optional build macro DINO_SPEEDUP_EN: the scroll tick shortens as the
// score passes each multiple of 16 (up to three speed levels).
module dino_obstacle_scroller #(
    parameter int unsigned TICK_DIV   = 12500000,
    parameter int unsigned JUMP_TICKS = 3,
    parameter int unsigned GAP_MIN    = 2,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic        start,
    input  logic        jump_req,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  player_hex,
    output logic [15:0] score,
    output logic        running,
    output logic        game_over
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam int unsigned GAP_W = $clog2(GAP_MIN + 2);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    localparam logic [1:0] CELL_EMPTY  = 2'd0;
    localparam logic [1:0] CELL_CACTUS = 2'd1;
    localparam logic [1:0] CELL_BIRD   = 2'd2;

    localparam logic [6:0] GLYPH_EMPTY  = 7'b1111111;
    localparam logic [6:0] GLYPH_CACTUS = 7'b1110111;
    localparam logic [6:0] GLYPH_BIRD   = 7'b1111110;
    localparam logic [6:0] PLAYER_LOW   = 7'b0100011;
    localparam logic [6:0] PLAYER_HIGH  = 7'b0011100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_OVER
    } state_t;

    state_t state_q, state_d;

    // Cells packed two bits each: [1:0] is hex0 (spawn side), [9:8] is hex4.
    logic [9:0]       cells_q, cells_d;
    logic [15:0]      score_q, score_d;
    logic [2:0]       air_q, air_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] term;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [15:0]      lfsr_q, lfsr_d;

    logic       in_run;
    logic       enter_run;
    logic       tick;
    logic       airborne;
    logic       jump_acc;
    logic       collision;
    logic       spawn;
    logic       lfsr_fb;
    logic [1:0] leaving;
    logic [1:0] new_cell;

    function automatic logic [6:0] cell_glyph(input logic [1:0] c);
        case (c)
            CELL_CACTUS: cell_glyph = GLYPH_CACTUS;
            CELL_BIRD:   cell_glyph = GLYPH_BIRD;
            default:     cell_glyph = GLYPH_EMPTY;
        endcase
    endfunction

    assign in_run    = (state_q == ST_RUN);
    assign enter_run = start && (state_q != ST_RUN);
    assign tick      = in_run && (cnt_q == term);
    assign airborne  = (air_q != 3'd0);
    // A jump is only taken from the ground during a game.
    assign jump_acc  = in_run && jump_req && !airborne;
    assign leaving   = cells_q[9:8];
    // A jump accepted on the tick cycle already counts as airborne for the
    // obstacle leaving hex4, so the player may jump "just in time".
    assign collision = tick && (((leaving == CELL_CACTUS) && !(airborne || jump_acc)) ||
                                ((leaving == CELL_BIRD)   &&  (airborne || jump_acc)));
    assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign spawn     = (gap_q >= GAP_W'(GAP_MIN)) && (lfsr_q[1:0] == 2'b11);
    assign new_cell  = spawn ? (lfsr_q[2] ? CELL_BIRD : CELL_CACTUS) : CELL_EMPTY;

`ifdef DINO_SPEEDUP_EN
    logic [1:0] level_q, level_d;

    // Terminal count of the scroll tick shrinks by half per speed level.
    always_comb begin
        case (level_q)
            2'd0:    term = CNT_W'(TICK_DIV - 1);
            2'd1:    term = CNT_W'((TICK_DIV >> 1) - 1);
            2'd2:    term = CNT_W'((TICK_DIV >> 2) - 1);
            default: term = CNT_W'((TICK_DIV >> 3) - 1);
        endcase
    end

    // Speed level rises whenever the score steps onto a multiple of 16.
    always_comb begin
        level_d = level_q;
        if (enter_run) begin
            level_d = 2'd0;
        end else if ((score_d != score_q) && (score_d[3:0] == 4'h0) && (level_q != 2'd3)) begin
            level_d = level_q + 2'd1;
        end
    end

    // Speed level register.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            level_q <= 2'd0;
        end else begin
            level_q <= level_d;
        end
    end
`else
    assign term = CNT_W'(TICK_DIV - 1);
`endif

    // Game state transitions: start begins a game, a collision ends it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)     state_d = ST_RUN;
            ST_RUN:  if (collision) state_d = ST_OVER;
            ST_OVER: if (start)     state_d = ST_RUN;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Game state register.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // World update: tick counting, jump timing, scroll, spawn and scoring.
    always_comb begin
        cells_d = cells_q;
        score_d = score_q;
        air_d   = air_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        lfsr_d  = lfsr_q;
        if (enter_run) begin
            // The LFSR keeps running across games so each game differs.
            cells_d = '0;
            score_d = '0;
            air_d   = '0;
            cnt_d   = '0;
            gap_d   = GAP_W'(GAP_MIN);
        end else if (in_run) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (jump_acc) begin
                air_d = 3'(JUMP_TICKS);
            end else if (tick && airborne) begin
                air_d = air_q - 3'd1;
            end
            if (tick) begin
                lfsr_d = {lfsr_q[14:0], lfsr_fb};
                // On a collision the world freezes with the obstacle in hex4.
                if (!collision) begin
                    if ((leaving != CELL_EMPTY) && (score_q != 16'hFFFF)) begin
                        score_d = score_q + 16'd1;
                    end
                    cells_d = {cells_q[7:0], new_cell};
                    if (spawn) begin
                        gap_d = '0;
                    end else if (gap_q < GAP_W'(GAP_MIN)) begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
        end
    end

    // World registers.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            cells_q <= '0;
            score_q <= '0;
            air_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= GAP_W'(GAP_MIN);
            lfsr_q  <= SEED;
        end else begin
            cells_q <= cells_d;
            score_q <= score_d;
            air_q   <= air_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            lfsr_q  <= lfsr_d;
        end
    end

    assign hex0       = cell_glyph(cells_q[1:0]);
    assign hex1       = cell_glyph(cells_q[3:2]);
    assign hex2       = cell_glyph(cells_q[5:4]);
    assign hex3       = cell_glyph(cells_q[7:6]);
    assign hex4       = cell_glyph(cells_q[9:8]);
    assign player_hex = airborne ? PLAYER_HIGH : PLAYER_LOW;
    assign score      = score_q;
    assign running    = (state_q == ST_RUN);
    assign game_over  = (state_q == ST_OVER);

endmodule

// File: tb/tb_dino_obstacle_scroller.sv
// Bench for dino_obstacle_scroller: a cycle model predicts every output
// snapshot into a queue as stimulus is driven; scenario tasks pop and
// compare after each clock edge and add targeted checks of their own.
`timescale 1ns/1ps
module tb_dino_obstacle_scroller;

    localparam int TD = 8;
    localparam int JT = 3;
    localparam int GM = 2;

    localparam logic [6:0] G_EMPTY  = 7'b1111111;
    localparam logic [6:0] G_CACTUS = 7'b1110111;
    localparam logic [6:0] G_BIRD   = 7'b1111110;
    localparam logic [6:0] P_LOW    = 7'b0100011;
    localparam logic [6:0] P_HIGH   = 7'b0011100;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        jump_req;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, player_hex;
    logic [15:0] score;
    logic        running, game_over;

    dino_obstacle_scroller #(
        .TICK_DIV(TD), .JUMP_TICKS(JT), .GAP_MIN(GM), .LFSR_SEED(16'hACE1)
    ) dut (
        .CLOCK_50(clk), .RESET(rst), .start(start), .jump_req(jump_req),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4),
        .player_hex(player_hex), .score(score), .running(running), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [59:0] sb_q[$];

    // Reference model state: m_state 0=IDLE 1=RUN 2=OVER; cells 0=EMPTY 1=CACTUS 2=BIRD.
    int          m_state;
    int          m_cell[5];
    int          m_score, m_air, m_cnt, m_gap, m_level;
    logic [15:0] m_lfsr;
    bit          m_tick_now, m_spawned;

    function automatic logic [6:0] tb_glyph(input int c);
        if (c == 1) return G_CACTUS;
        if (c == 2) return G_BIRD;
        return G_EMPTY;
    endfunction

    function automatic logic [59:0] m_snap();
        return {tb_glyph(m_cell[4]), tb_glyph(m_cell[3]), tb_glyph(m_cell[2]),
                tb_glyph(m_cell[1]), tb_glyph(m_cell[0]),
                ((m_air != 0) ? P_HIGH : P_LOW), m_score[15:0],
                (m_state == 1), (m_state == 2)};
    endfunction

    function automatic int m_term();
`ifdef DINO_SPEEDUP_EN
        return (TD >> m_level) - 1;
`else
        return TD - 1;
`endif
    endfunction

    function automatic bit m_will_tick();
        return (m_state == 1) && (m_cnt == m_term());
    endfunction

    task automatic model_reset();
        m_state = 0;
        for (int i = 0; i < 5; i++) m_cell[i] = 0;
        m_score = 0; m_air = 0; m_cnt = 0; m_gap = GM; m_level = 0;
        m_lfsr = 16'hACE1;
        m_tick_now = 0; m_spawned = 0;
    endtask

    // Advance the model by one clock with the given inputs.
    task automatic model_eval(input bit s, input bit j);
        bit   tk, air, acc, coll;
        int   leave;
        logic fb;
        tk  = m_will_tick();
        air = (m_air != 0);
        acc = (m_state == 1) && j && !air;
        m_tick_now = tk;
        m_spawned  = 0;
        if (m_state != 1) begin
            if (s) begin
                m_state = 1;
                for (int i = 0; i < 5; i++) m_cell[i] = 0;
                m_score = 0; m_air = 0; m_cnt = 0; m_gap = GM; m_level = 0;
            end
            return;
        end
        m_cnt = tk ? 0 : m_cnt + 1;
        if (!tk) begin
            if (acc) m_air = JT;
            return;
        end
        leave = m_cell[4];
        coll  = ((leave == 1) && !(air || acc)) || ((leave == 2) && (air || acc));
        fb    = m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10];
        if (coll) begin
            m_state = 2;
        end else begin
            if ((leave != 0) && (m_score < 65535)) begin
                m_score++;
                if ((m_score % 16 == 0) && (m_level < 3)) m_level++;
            end
            for (int i = 4; i > 0; i--) m_cell[i] = m_cell[i-1];
            if ((m_gap >= GM) && (m_lfsr[1:0] == 2'b11)) begin
                m_cell[0] = m_lfsr[2] ? 2 : 1;
                m_gap = 0;
                m_spawned = 1;
            end else begin
                m_cell[0] = 0;
                if (m_gap < GM) m_gap++;
            end
        end
        m_lfsr = {m_lfsr[14:0], fb};
        if (acc) m_air = JT;
        else if (air) m_air--;
    endtask

    // Drive one cycle of stimulus and queue the predicted outputs.
    task automatic step(input bit s, input bit j);
        @(negedge clk);
        start = s;
        jump_req = j;
        model_eval(s, j);
        sb_q.push_back(m_snap());
        @(posedge clk);
        #1;
        start = 1'b0;
        jump_req = 1'b0;
    endtask

    // Play safely (restart when not running, jump cactus at the last tick)
    // until an obstacle of type 'want' is about to leave hex4 on the next tick.
    task automatic advance(input int want, output bit found);
        logic [59:0] exp, act;
        bit s, j;
        found = 0;
        for (int c = 0; c < 4000; c++) begin
            if (m_will_tick() && (m_cell[4] == want) && ((want != 1) || (m_air == 0))) begin
                found = 1;
                break;
            end
            s = (m_state != 1);
            j = m_will_tick() && (m_cell[4] == 1) && (m_air == 0);
            step(s, j);
            exp = sb_q.pop_front();
            act = {hex4, hex3, hex2, hex1, hex0, player_hex, score, running, game_over};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL advance: got %h want %h", act, exp);
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL advance_timeout: obstacle type %0d reached hex4 got 0 want 1", want);
        end
    endtask

    task automatic test_reset();
        logic [59:0] exp, act;
        rst = 1'b1; start = 1'b0; jump_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        sb_q.delete();
        checks++;
        if ({hex4, hex3, hex2, hex1, hex0} !== {5{G_EMPTY}}) begin
            errors++;
            $display("FAIL reset_cells: got %h want %h", {hex4, hex3, hex2, hex1, hex0}, {5{G_EMPTY}});
        end
        checks++;
        if (player_hex !== P_LOW) begin
            errors++;
            $display("FAIL reset_player: got %b want %b", player_hex, P_LOW);
        end
        checks++;
        if ({score, running, game_over} !== 18'd0) begin
            errors++;
            $display("FAIL reset_status: got score=%0d run=%b over=%b want 0 0 0", score, running, game_over);
        end
        @(negedge clk);
        rst = 1'b0;
        // Idle for 100 cycles; a jump request while idle must be ignored.
        for (int i = 0; i < 100; i++) begin
            step(1'b0, i == 40);
            exp = sb_q.pop_front();
            act = {hex4, hex3, hex2, hex1, hex0, player_hex, score, running, game_over};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL idle_hold: got %h want %h", act, exp);
            end
        end
        checks++;
        if ({hex4, hex3, hex2, hex1, hex0, player_hex, running} !== {{5{G_EMPTY}}, P_LOW, 1'b0}) begin
            errors++;
            $display("FAIL idle_final: got %h want %h", {hex4, hex3, hex2, hex1, hex0, player_hex, running},
                     {{5{G_EMPTY}}, P_LOW, 1'b0});
        end
    endtask

    task automatic test_scroll();
        logic [59:0] exp, act;
        int   ticks, ntick, typ;
        bit   done;
        logic [6:0] g;
        ticks = 0; ntick = -1; typ = 0; done = 0; g = G_EMPTY;
        step(1'b1, 1'b0);
        exp = sb_q.pop_front();
        act = {hex4, hex3, hex2, hex1, hex0, player_hex, score, running, game_over};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL scroll_start: got %h want %h", act, exp);
        end
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL scroll_running: got %b want 1", running);
        end
        for (int c = 0; c < 3000 && !done; c++) begin
            // A start pulse in the middle of a game must be ignored.
            step(c == 3, 1'b0);
            exp = sb_q.pop_front();
            act = {hex4, hex3, hex2, hex1, hex0, player_hex, score, running, game_over};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL scroll: got %h want %h", act, exp);
            end
            if (m_tick_now) begin
                ticks++;
                if (ntick < 0 && m_spawned) begin
                    ntick = ticks;
                    typ   = m_cell[0];
                    g     = (typ == 2) ? G_BIRD : G_CACTUS;
                    checks++;
                    if (hex0 !== g) begin
                        errors++;
                        $display("FAIL scroll_spawn: got %b want %b", hex0, g);
                    end
                end else if (ntick >= 0 && (ticks == ntick + 1 || ticks == ntick + 2)) begin
                    checks++;
                    if (hex0 !== G_EMPTY) begin
                        errors++;
                        $display("FAIL scroll_gap: got %b want %b", hex0, G_EMPTY);
                    end
                end else if (ntick >= 0 && ticks == ntick + 4) begin
                    checks++;
                    if (hex4 !== g) begin
                        errors++;
                        $display("FAIL scroll_arrive: got %b want %b", hex4, g);
                    end
                    done = 1;
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL scroll_timeout: arrival seen got 0 want 1");
        end
    endtask

    task automatic test_cactus_hit();
        logic [59:0] exp, act;
        bit found;
        int sc;
        advance(1, found);
        if (!found) return;
        sc = m_score;
        step(1'b0, 1'b0);
        exp = sb_q.pop_front();
        act = {hex4, hex3, hex2, hex1, hex0, player_hex, score, running, game_over};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cactus_hit: got %h want %h", act, exp);
        end
        checks++;
        if ({game_over, running, hex4, score} !== {1'b1, 1'b0, G_CACTUS, sc[15:0]}) begin
            errors++;
            $display("FAIL cactus_hit_state: got over=%b run=%b hex4=%b score=%0d want 1 0 %b %0d",
                     game_over, running, hex4, score, G_CACTUS, sc);
        end
        for (int i = 0; i < 50; i++) begin
            step(1'b0, i == 10);
            exp = sb_q.pop_front();
            act = {hex4, hex3, hex2, hex1, hex0, player_hex, score, running, game_over};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL cactus_frozen: got %h want %h", act, exp);
            end
        end
        checks++;
        if ({game_over, hex4, score} !== {1'b1, G_CACTUS, sc[15:0]}) begin
            errors++;
            $display("FAIL cactus_frozen_end: got over=%b hex4=%b score=%0d want 1 %b %0d",
                     game_over, hex4, score, G_CACTUS, sc);
        end
    endtask

    task automatic test_cactus_cleared();
        logic [59:0] exp, act;
        bit found, first;
        int sc, tk;
        logic [6:0] pw;
        advance(1, found);
        if (!found) return;
        sc = m_score;
        step(1'b0, 1'b1);
        exp = sb_q.pop_front();
        act = {hex4, hex3, hex2, hex1, hex0, player_hex, score, running, game_over};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cactus_clear: got %h want %h", act, exp);
        end
        checks++;
        if ({score, player_hex, running} !== {sc[15:0] + 16'd1, P_HIGH, 1'b1}) begin
            errors++;
            $display("FAIL cactus_clear_state: got score=%0d player=%b run=%b want %0d %b 1",
                     score, player_hex, running, sc + 1, P_HIGH);
        end
        tk = 0; first = 1;
        for (int c = 0; c < 200 && tk < 3; c++) begin
            // Second jump while airborne must not extend the jump.
            step(1'b0, first);
            first = 0;
            exp = sb_q.pop_front();
            act = {hex4, hex3, hex2, hex1, hex0, player_hex, score, running, game_over};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL airborne: got %h want %h", act, exp);
            end
            if (m_tick_now) begin
                tk++;
                pw = (tk < 3) ? P_HIGH : P_LOW;
                checks++;
                if (player_hex !== pw) begin
                    errors++;
                    $display("FAIL air_tick%0d: got %b want %b", tk, player_hex, pw);
                end
            end
        end
        if (tk < 3) begin
            checks++;
            errors++;
            $display("FAIL air_timeout: ticks got %0d want 3", tk);
        end
    endtask

    task automatic test_bird_hit();
        logic [59:0] exp, act;
        bit found;
        advance(2, found);
        if (!found) return;
        step(1'b0, 1'b1);
        exp = sb_q.pop_front();
        act = {hex4, hex3, hex2, hex1, hex0, player_hex, score, running, game_over};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL bird_hit: got %h want %h", act, exp);
        end
        checks++;
        if ({game_over, running, hex4} !== {1'b1, 1'b0, G_BIRD}) begin
            errors++;
            $display("FAIL bird_hit_state: got over=%b run=%b hex4=%b want 1 0 %b",
                     game_over, running, hex4, G_BIRD);
        end
        step(1'b1, 1'b0);
        exp = sb_q.pop_front();
        act = {hex4, hex3, hex2, hex1, hex0, player_hex, score, running, game_over};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL restart: got %h want %h", act, exp);
        end
        checks++;
        if ({running, game_over, score, hex4, hex3, hex2, hex1, hex0} !==
            {1'b1, 1'b0, 16'd0, {5{G_EMPTY}}}) begin
            errors++;
            $display("FAIL restart_state: got run=%b over=%b score=%0d cells=%h want 1 0 0 %h",
                     running, game_over, score, {hex4, hex3, hex2, hex1, hex0}, {5{G_EMPTY}});
        end
    endtask

    task automatic test_reset_mid();
        logic [59:0] exp, act;
        bit s, j;
        for (int c = 0; c < 6000; c++) begin
            if ((m_state == 1) && (m_score == 5) && (m_air == 2)) break;
            s = (m_state != 1);
            j = m_will_tick() && (m_cell[4] == 1) && (m_air == 0);
            step(s, j);
            exp = sb_q.pop_front();
            act = {hex4, hex3, hex2, hex1, hex0, player_hex, score, running, game_over};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL mid_play: got %h want %h", act, exp);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        sb_q.delete();
        checks++;
        if ({hex4, hex3, hex2, hex1, hex0, player_hex, score, running, game_over} !==
            {{5{G_EMPTY}}, P_LOW, 16'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid: got %h want %h",
                     {hex4, hex3, hex2, hex1, hex0, player_hex, score, running, game_over},
                     {{5{G_EMPTY}}, P_LOW, 16'd0, 1'b0, 1'b0});
        end
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b0);
        exp = sb_q.pop_front();
        act = {hex4, hex3, hex2, hex1, hex0, player_hex, score, running, game_over};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL post_reset: got %h want %h", act, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        jump_req = 1'b0;
        model_reset();
        test_reset();
        test_scroll();
        test_cactus_hit();
        test_cactus_cleared();
        test_bird_hit();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
